// File: rtl/voxel_dda_pkg.sv
// Shared types and encodings for the voxel DDA marcher: FSM states, result status,
// face codes, step-sign codes and the alpha field position inside a voxel word.
package voxel_dda_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_TEST  = 3'd3,
    ST_EMIT  = 3'd4
  } state_e;

  localparam logic [1:0] STAT_HIT        = 2'd0;
  localparam logic [1:0] STAT_EXIT_GRID  = 2'd1;
  localparam logic [1:0] STAT_STEP_LIMIT = 2'd2;

  localparam logic [1:0] FACE_X    = 2'd0;
  localparam logic [1:0] FACE_Y    = 2'd1;
  localparam logic [1:0] FACE_Z    = 2'd2;
  localparam logic [1:0] FACE_NONE = 2'd3;

  localparam logic [1:0] SIGN_NONE = 2'b00;
  localparam logic [1:0] SIGN_POS  = 2'b01;
  localparam logic [1:0] SIGN_RSVD = 2'b10;
  localparam logic [1:0] SIGN_NEG  = 2'b11;

  localparam int ALPHA_MSB = 47;
  localparam int ALPHA_LSB = 40;

  // The reserved code 10 walks nowhere, same as 00.
  function automatic logic sign_active(input logic [1:0] s);
    return (s == SIGN_POS) || (s == SIGN_NEG);
  endfunction

endpackage

// File: rtl/voxel_dda_axis_select.sv
// Picks the axis with the smallest tmax among axes that actually move;
// ties go X, then Y, then Z. o_none flags a ray with no moving axis.
module voxel_dda_axis_select
  import voxel_dda_pkg::*;
#(
  parameter int T_WIDTH = 16
) (
  input  logic [T_WIDTH-1:0] i_tmax_x,
  input  logic [T_WIDTH-1:0] i_tmax_y,
  input  logic [T_WIDTH-1:0] i_tmax_z,
  input  logic [1:0]         i_sign_x,
  input  logic [1:0]         i_sign_y,
  input  logic [1:0]         i_sign_z,
  output logic [1:0]         o_axis,
  output logic               o_none
);

  logic w_ax, w_ay, w_az;

  assign w_ax = sign_active(i_sign_x);
  assign w_ay = sign_active(i_sign_y);
  assign w_az = sign_active(i_sign_z);

  // Masked minimum with X > Y > Z priority on equal tmax.
  always_comb begin
    o_axis = FACE_NONE;
    o_none = 1'b1;
    if (w_ax && (!w_ay || (i_tmax_x <= i_tmax_y)) && (!w_az || (i_tmax_x <= i_tmax_z))) begin
      o_axis = FACE_X;
      o_none = 1'b0;
    end else if (w_ay && (!w_az || (i_tmax_y <= i_tmax_z))) begin
      o_axis = FACE_Y;
      o_none = 1'b0;
    end else if (w_az) begin
      o_axis = FACE_Z;
      o_none = 1'b0;
    end else begin
      o_axis = FACE_NONE;
      o_none = 1'b1;
    end
  end

endmodule

// File: rtl/voxel_dda_marcher.sv
// Per-ray 3-D DDA voxel marcher with request/grant + rvalid memory port.
// Define VOXEL_DDA_STATS_EN to build the stat_rays/stat_steps counters.
module voxel_dda_marcher
  import voxel_dda_pkg::*;
#(
  parameter int GRID_LOG2    = 6,
  parameter int T_WIDTH      = 16,
  parameter int MAX_STEPS    = 128,
  parameter int ALPHA_THRESH = 10,
  parameter int TAG_WIDTH    = 20,
  parameter int STEP_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ray_valid,
  output logic                   ray_ready,
  input  logic [TAG_WIDTH-1:0]   ray_tag,
  input  logic [GRID_LOG2-1:0]   ray_vx,
  input  logic [GRID_LOG2-1:0]   ray_vy,
  input  logic [GRID_LOG2-1:0]   ray_vz,
  input  logic [1:0]             ray_sx,
  input  logic [1:0]             ray_sy,
  input  logic [1:0]             ray_sz,
  input  logic [T_WIDTH-1:0]     ray_tmax_x,
  input  logic [T_WIDTH-1:0]     ray_tmax_y,
  input  logic [T_WIDTH-1:0]     ray_tmax_z,
  input  logic [T_WIDTH-1:0]     ray_tdelta_x,
  input  logic [T_WIDTH-1:0]     ray_tdelta_y,
  input  logic [T_WIDTH-1:0]     ray_tdelta_z,
  output logic                   mem_req,
  output logic [3*GRID_LOG2-1:0] mem_addr,
  input  logic                   mem_gnt,
  input  logic                   mem_rvalid,
  input  logic [63:0]            mem_rdata,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [TAG_WIDTH-1:0]   res_tag,
  output logic [1:0]             res_status,
  output logic [GRID_LOG2-1:0]   res_vx,
  output logic [GRID_LOG2-1:0]   res_vy,
  output logic [GRID_LOG2-1:0]   res_vz,
  output logic [1:0]             res_face,
  output logic [T_WIDTH-1:0]     res_t,
  output logic [STEP_W-1:0]      res_steps,
  output logic [63:0]            res_data,
  output logic [31:0]            stat_rays,
  output logic [31:0]            stat_steps
);

  state_e                 r_state;
  logic [TAG_WIDTH-1:0]   r_tag;
  logic [GRID_LOG2-1:0]   r_vx, r_vy, r_vz;
  logic [1:0]             r_sx, r_sy, r_sz;
  logic [T_WIDTH-1:0]     r_tmx, r_tmy, r_tmz;
  logic [T_WIDTH-1:0]     r_tdx, r_tdy, r_tdz;
  logic [STEP_W-1:0]      r_steps;
  logic [1:0]             r_face;
  logic [T_WIDTH-1:0]     r_t;
  logic [63:0]            r_rdata;
  logic [1:0]             r_status;
  logic [63:0]            r_res_data;
  logic                   r_ray_ready;
  logic                   r_mem_req;
  logic                   r_res_valid;

  logic [1:0]             w_axis;
  logic                   w_none;
  logic [GRID_LOG2-1:0]   w_coord, w_coord_next;
  logic [1:0]             w_sign;
  logic [T_WIDTH-1:0]     w_tmax, w_tdelta, w_tmax_next;
  logic [T_WIDTH:0]       w_tmax_sum;
  logic                   w_hit, w_limit, w_edge, w_exit;

  voxel_dda_axis_select #(.T_WIDTH(T_WIDTH)) u_axis_select (
    .i_tmax_x (r_tmx),
    .i_tmax_y (r_tmy),
    .i_tmax_z (r_tmz),
    .i_sign_x (r_sx),
    .i_sign_y (r_sy),
    .i_sign_z (r_sz),
    .o_axis   (w_axis),
    .o_none   (w_none)
  );

  // Route the selected axis' coordinate, sign and timing to the step datapath.
  always_comb begin
    w_coord  = r_vx;
    w_sign   = r_sx;
    w_tmax   = r_tmx;
    w_tdelta = r_tdx;
    case (w_axis)
      FACE_Y: begin
        w_coord  = r_vy;
        w_sign   = r_sy;
        w_tmax   = r_tmy;
        w_tdelta = r_tdy;
      end
      FACE_Z: begin
        w_coord  = r_vz;
        w_sign   = r_sz;
        w_tmax   = r_tmz;
        w_tdelta = r_tdz;
      end
      default: begin
        w_coord  = r_vx;
        w_sign   = r_sx;
        w_tmax   = r_tmx;
        w_tdelta = r_tdx;
      end
    endcase
  end

  assign w_hit        = (r_rdata != 64'd0) && (r_rdata[ALPHA_MSB:ALPHA_LSB] > 8'(ALPHA_THRESH));
  assign w_limit      = (r_steps == STEP_W'(MAX_STEPS));
  assign w_edge       = ((w_sign == SIGN_POS) && (w_coord == {GRID_LOG2{1'b1}})) ||
                        ((w_sign == SIGN_NEG) && (w_coord == {GRID_LOG2{1'b0}}));
  assign w_exit       = w_none || w_edge;
  assign w_coord_next = (w_sign == SIGN_POS) ? (w_coord + GRID_LOG2'(1)) : (w_coord - GRID_LOG2'(1));
  assign w_tmax_sum   = {1'b0, w_tmax} + {1'b0, w_tdelta};
  assign w_tmax_next  = w_tmax_sum[T_WIDTH] ? {T_WIDTH{1'b1}} : w_tmax_sum[T_WIDTH-1:0];

  // Ray FSM; every output is driven straight from a register here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_tag       <= '0;
      r_vx        <= '0;
      r_vy        <= '0;
      r_vz        <= '0;
      r_sx        <= 2'b00;
      r_sy        <= 2'b00;
      r_sz        <= 2'b00;
      r_tmx       <= '0;
      r_tmy       <= '0;
      r_tmz       <= '0;
      r_tdx       <= '0;
      r_tdy       <= '0;
      r_tdz       <= '0;
      r_steps     <= '0;
      r_face      <= 2'd0;
      r_t         <= '0;
      r_rdata     <= 64'd0;
      r_status    <= 2'd0;
      r_res_data  <= 64'd0;
      r_ray_ready <= 1'b1;
      r_mem_req   <= 1'b0;
      r_res_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (ray_valid) begin
            r_tag       <= ray_tag;
            r_vx        <= ray_vx;
            r_vy        <= ray_vy;
            r_vz        <= ray_vz;
            r_sx        <= ray_sx;
            r_sy        <= ray_sy;
            r_sz        <= ray_sz;
            r_tmx       <= ray_tmax_x;
            r_tmy       <= ray_tmax_y;
            r_tmz       <= ray_tmax_z;
            r_tdx       <= ray_tdelta_x;
            r_tdy       <= ray_tdelta_y;
            r_tdz       <= ray_tdelta_z;
            r_steps     <= '0;
            r_face      <= FACE_NONE;
            r_t         <= '0;
            r_ray_ready <= 1'b0;
            r_mem_req   <= 1'b1;
            r_state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (mem_gnt) begin
            r_mem_req <= 1'b0;
            r_state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            r_rdata <= mem_rdata;
            r_steps <= r_steps + STEP_W'(1);
            r_state <= ST_TEST;
          end
        end
        ST_TEST: begin
          if (w_hit) begin
            r_status    <= STAT_HIT;
            r_res_data  <= r_rdata;
            r_res_valid <= 1'b1;
            r_state     <= ST_EMIT;
          end else if (w_limit) begin
            r_status    <= STAT_STEP_LIMIT;
            r_res_data  <= 64'd0;
            r_res_valid <= 1'b1;
            r_state     <= ST_EMIT;
          end else if (w_exit) begin
            r_status    <= STAT_EXIT_GRID;
            r_res_data  <= 64'd0;
            r_res_valid <= 1'b1;
            r_state     <= ST_EMIT;
          end else begin
            case (w_axis)
              FACE_X: begin
                r_vx  <= w_coord_next;
                r_tmx <= w_tmax_next;
              end
              FACE_Y: begin
                r_vy  <= w_coord_next;
                r_tmy <= w_tmax_next;
              end
              FACE_Z: begin
                r_vz  <= w_coord_next;
                r_tmz <= w_tmax_next;
              end
              default: begin
                r_tmx <= r_tmx;
              end
            endcase
            r_face    <= w_axis;
            r_t       <= w_tmax;
            r_mem_req <= 1'b1;
            r_state   <= ST_ISSUE;
          end
        end
        ST_EMIT: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_ray_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_res_valid <= 1'b0;
          r_mem_req   <= 1'b0;
          r_ray_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign ray_ready  = r_ray_ready;
  assign mem_req    = r_mem_req;
  assign mem_addr   = {r_vx, r_vy, r_vz};
  assign res_valid  = r_res_valid;
  assign res_tag    = r_tag;
  assign res_status = r_status;
  assign res_vx     = r_vx;
  assign res_vy     = r_vy;
  assign res_vz     = r_vz;
  assign res_face   = r_face;
  assign res_t      = r_t;
  assign res_steps  = r_steps;
  assign res_data   = r_res_data;

`ifdef VOXEL_DDA_STATS_EN
  logic [31:0] r_stat_rays;
  logic [31:0] r_stat_steps;

  // Free-running activity counters, wrapping naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_rays  <= 32'd0;
      r_stat_steps <= 32'd0;
    end else begin
      if ((r_state == ST_EMIT) && res_ready) begin
        r_stat_rays <= r_stat_rays + 32'd1;
      end
      if ((r_state == ST_WAIT) && mem_rvalid) begin
        r_stat_steps <= r_stat_steps + 32'd1;
      end
    end
  end

  assign stat_rays  = r_stat_rays;
  assign stat_steps = r_stat_steps;
`else
  assign stat_rays  = 32'd0;
  assign stat_steps = 32'd0;
`endif

endmodule
